// File: rtl/nphase_clock_generator_if.sv
// rtl/nphase_clock_generator_if.sv - control inputs and phase outputs of the n-phase clock generator
interface nphase_clock_generator_if #(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 8
);
  localparam int IDX_W = $clog2(NUM_PHASES);

  logic                  en;
  logic                  dir;
  logic [CNT_W-1:0]      phase_len;
  logic [CNT_W-1:0]      gap_len;
  logic [NUM_PHASES-1:0] phase;
  logic [IDX_W-1:0]      phase_idx;
  logic                  cycle_start;
  logic                  busy;

  modport master (
    output en, dir, phase_len, gap_len,
    input  phase, phase_idx, cycle_start, busy
  );

  modport slave (
    input  en, dir, phase_len, gap_len,
    output phase, phase_idx, cycle_start, busy
  );
endinterface

// File: rtl/nphase_clock_generator.sv
// rtl/nphase_clock_generator.sv - rotating one-hot phase enables with programmable width, gap and direction
module nphase_clock_generator #(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 8
) (
  input logic                        clk,
  input logic                        rst_n,
  nphase_clock_generator_if.slave    bus
);
  localparam int IDX_W = $clog2(NUM_PHASES);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_PHASES-1:0] phase_q, phase_d;
  logic                  cycle_start_q, cycle_start_d;
  logic                  busy_q, busy_d;

  logic [IDX_W-1:0]      idx_step;
  logic [CNT_W-1:0]      act_init;
  logic [CNT_W-1:0]      gap_init;
  logic                  start_win;

  // The counter holds remaining cycles minus one, so a zero length still yields a one-cycle window.
  assign act_init = (bus.phase_len == '0) ? '0 : bus.phase_len - CNT_W'(1);
  assign gap_init = bus.gap_len - CNT_W'(1);

  // Neighbouring index in the requested direction, wrapping at both ends.
  always_comb begin
    if (bus.dir) begin
      idx_step = (idx_q == '0) ? IDX_W'(NUM_PHASES - 1) : idx_q - IDX_W'(1);
    end else begin
      idx_step = (idx_q == IDX_W'(NUM_PHASES - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // State register; outputs are registered alongside so every output is glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      phase_q       <= '0;
      cycle_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      phase_q       <= phase_d;
      cycle_start_q <= cycle_start_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state: window sequencing; en only matters on a window's final cycle or anywhere in a gap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    start_win = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          state_d   = S_ACTIVE;
          idx_d     = '0;
          cnt_d     = act_init;
          start_win = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!bus.en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (bus.gap_len == '0) begin
          idx_d     = idx_step;
          cnt_d     = act_init;
          start_win = 1'b1;
        end else begin
          state_d = S_GAP;
          cnt_d   = gap_init;
        end
      end
      S_GAP: begin
        if (!bus.en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d   = S_ACTIVE;
          idx_d     = idx_step;
          cnt_d     = act_init;
          start_win = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state they describe.
  always_comb begin
    phase_d = '0;
    if (state_d == S_ACTIVE) begin
      phase_d = NUM_PHASES'(1) << idx_d;
    end
    cycle_start_d = start_win && (idx_d == '0);
    busy_d        = (state_d != S_IDLE);
  end

  assign bus.phase       = phase_q;
  assign bus.phase_idx   = idx_q;
  assign bus.cycle_start = cycle_start_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_nphase_clock_generator.sv
// tb/tb_nphase_clock_generator.sv - directed and random checks of three generator widths against a reference model
module tb_nphase_clock_generator;
  logic       clk;
  logic       rstn;
  logic       en;
  logic       dir;
  logic [7:0] plen;
  logic [7:0] glen;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    bit run;
    bit gap;
    bit cs;
    int idx;
    int rem;
  } mdl_t;

  mdl_t m3, m4, m8;

  nphase_clock_generator_if #(.NUM_PHASES(3), .CNT_W(8)) if3 ();
  nphase_clock_generator_if #(.NUM_PHASES(4), .CNT_W(8)) if4 ();
  nphase_clock_generator_if #(.NUM_PHASES(8), .CNT_W(8)) if8 ();

  assign if3.en = en;  assign if3.dir = dir;  assign if3.phase_len = plen;  assign if3.gap_len = glen;
  assign if4.en = en;  assign if4.dir = dir;  assign if4.phase_len = plen;  assign if4.gap_len = glen;
  assign if8.en = en;  assign if8.dir = dir;  assign if8.phase_len = plen;  assign if8.gap_len = glen;

  nphase_clock_generator #(.NUM_PHASES(3), .CNT_W(8)) dut3 (.clk(clk), .rst_n(rstn), .bus(if3));
  nphase_clock_generator #(.NUM_PHASES(4), .CNT_W(8)) dut4 (.clk(clk), .rst_n(rstn), .bus(if4));
  nphase_clock_generator #(.NUM_PHASES(8), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rstn), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a window is a run of 'rem' cycles either lit (phase idx) or dark (gap).
  function automatic mdl_t mstep(mdl_t m, int n, bit rst_ok, bit run_req, bit rev, int plen_v, int glen_v);
    mdl_t r;
    int   nxt;
    int   width;
    r     = m;
    r.cs  = 1'b0;
    nxt   = rev ? (m.idx + n - 1) % n : (m.idx + 1) % n;
    width = (plen_v == 0) ? 1 : plen_v;
    if (!rst_ok) begin
      r.run = 0; r.gap = 0; r.idx = 0; r.rem = 0;
    end else if (!m.run) begin
      if (run_req) begin
        r.run = 1; r.gap = 0; r.idx = 0; r.rem = width; r.cs = 1;
      end
    end else if (m.gap && !run_req) begin
      r.run = 0; r.gap = 0;
    end else if (m.rem > 1) begin
      r.rem = m.rem - 1;
    end else if (!run_req) begin
      r.run = 0;
    end else if (!m.gap && glen_v > 0) begin
      r.gap = 1; r.rem = glen_v;
    end else begin
      r.gap = 0; r.idx = nxt; r.rem = width; r.cs = (nxt == 0);
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_phase(mdl_t m);
    return (m.run && !m.gap) ? (32'd1 << m.idx) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string tag, input mdl_t m, input logic [31:0] ph,
                           input logic [31:0] pidx, input logic cs, input logic bz);
    chk({tag, ".phase"}, ph, exp_phase(m));
    chk({tag, ".idx"}, pidx, 32'(m.idx));
    chk({tag, ".cs"}, {31'd0, cs}, {31'd0, m.cs});
    chk({tag, ".busy"}, {31'd0, bz}, {31'd0, m.run});
    chk({tag, ".onehot"}, {31'd0, ($countones(ph) <= 1)}, 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    m3 = mstep(m3, 3, rstn, en, dir, int'(plen), int'(glen));
    m4 = mstep(m4, 4, rstn, en, dir, int'(plen), int'(glen));
    m8 = mstep(m8, 8, rstn, en, dir, int'(plen), int'(glen));
    #1;
    check_dut("n3", m3, 32'(if3.phase), 32'(if3.phase_idx), if3.cycle_start, if3.busy);
    check_dut("n4", m4, 32'(if4.phase), 32'(if4.phase_idx), if4.cycle_start, if4.busy);
    check_dut("n8", m8, 32'(if8.phase), 32'(if8.phase_idx), if8.cycle_start, if8.busy);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    en   = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    logic [3:0] leg [8];
    logic [7:0] rev8 [3];
    logic [2:0] rev3 [3];
    int zc;
    leg  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    rev8 = '{8'h01, 8'h80, 8'h40};
    rev3 = '{3'h1, 3'h4, 3'h2};
    m3 = '0; m4 = '0; m8 = '0;
    rstn = 1'b0; en = 1'b0; dir = 1'b0; plen = 8'd1; glen = 8'd0;

    // Legacy rotation
    do_reset();
    chk("reset.phase", 32'(if4.phase), 32'd0);
    chk("reset.busy", {31'd0, if4.busy}, 32'd0);
    chk("reset.idx", 32'(if4.phase_idx), 32'd0);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("legacy.phase", 32'(if4.phase), 32'(leg[i]));
      chk("legacy.cs", {31'd0, if4.cycle_start}, {31'd0, (i % 4 == 0)});
    end

    // Width 3, gap 2: period 20
    do_reset();
    plen = 8'd3; glen = 8'd2; en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tick();
      chk("wg.phase", 32'(if4.phase), (t % 5 < 3) ? (32'd1 << ((t / 5) % 4)) : 32'd0);
      chk("wg.cs", {31'd0, if4.cycle_start}, {31'd0, (t % 20 == 0)});
    end

    // Descending, then flip to ascending during the 0100 window
    do_reset();
    plen = 8'd1; glen = 8'd0; dir = 1'b1; en = 1'b1;
    tick(); chk("rev.0", 32'(if4.phase), 32'h1);
    tick(); chk("rev.1", 32'(if4.phase), 32'h8);
    tick(); chk("rev.2", 32'(if4.phase), 32'h4);
    dir = 1'b0;
    tick(); chk("flip.0", 32'(if4.phase), 32'h8);
    tick(); chk("flip.1", 32'(if4.phase), 32'h1);

    // Graceful stop during phase 1, then restart and an en glitch
    do_reset();
    plen = 8'd4; glen = 8'd0; dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    en = 1'b0;
    chk("stop.c2", 32'(if4.phase), 32'h2);
    tick(); chk("stop.c3", 32'(if4.phase), 32'h2);
    tick(); chk("stop.c4", 32'(if4.phase), 32'h2);
    tick(); chk("stop.off", 32'(if4.phase), 32'h0);
    chk("stop.busy", {31'd0, if4.busy}, 32'd0);
    tick(); chk("stop.hold", 32'(if4.phase), 32'h0);
    en = 1'b1;
    tick(); chk("restart.phase", 32'(if4.phase), 32'h1);
    chk("restart.cs", {31'd0, if4.cycle_start}, 32'd1);
    en = 1'b0; tick();
    en = 1'b1; tick(); tick();
    tick(); chk("glitch.next", 32'(if4.phase), 32'h2);

    // Synchronous reset in a gap, then in an active window
    do_reset();
    plen = 8'd2; glen = 8'd3; en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rstn = 1'b0;
    #2;
    chk("rst.sync_busy", {31'd0, if4.busy}, 32'd1);
    tick();
    chk("rst.gap.phase", 32'(if4.phase), 32'h0);
    chk("rst.gap.busy", {31'd0, if4.busy}, 32'd0);
    rstn = 1'b1;
    tick(); chk("rst.restart", 32'(if4.phase), 32'h1);
    chk("rst.restart.cs", {31'd0, if4.cycle_start}, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("rst.pre_act", 32'(if4.phase_idx), 32'd1);
    rstn = 1'b0;
    tick();
    chk("rst.act.idx", 32'(if4.phase_idx), 32'd0);
    chk("rst.act.phase", 32'(if4.phase), 32'h0);
    rstn = 1'b1;
    tick(); chk("rst.act.restart", 32'(if4.phase), 32'h1);

    // Zero length, wrap on 3 and 8 phases both directions
    do_reset();
    plen = 8'd0; glen = 8'd0; dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("wrap3.asc", 32'(if3.phase), 32'd1 << (i % 3));
      chk("wrap8.asc", 32'(if8.phase), 32'd1 << (i % 8));
    end
    do_reset();
    dir = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wrap8.desc", 32'(if8.phase), 32'(rev8[i]));
      chk("wrap3.desc", 32'(if3.phase), 32'(rev3[i]));
    end

    // Maximum gap
    do_reset();
    plen = 8'd1; glen = 8'd255; dir = 1'b0; en = 1'b1;
    tick(); chk("gap255.first", 32'(if4.phase), 32'h1);
    zc = 0;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (if4.phase == 4'h0) zc++;
    end
    chk("gap255.len", 32'(zc), 32'd255);
    tick(); chk("gap255.next", 32'(if4.phase), 32'h2);

    // Length change mid-window leaves the current window intact
    do_reset();
    plen = 8'd5; glen = 8'd0; en = 1'b1;
    tick(); tick();
    plen = 8'd1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("midlen.hold", 32'(if4.phase), 32'h1);
    end
    tick(); chk("midlen.next", 32'(if4.phase), 32'h2);
    tick(); chk("midlen.short", 32'(if4.phase), 32'h4);

    // Random stimulus against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rstn = ($urandom_range(0, 99) != 0);
      en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) dir = $urandom_range(0, 1) == 1;
      plen = 8'($urandom_range(0, 4));
      glen = 8'($urandom_range(0, 3));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nphase_clock_generator.md
Name: nphase_clock_generator

Overview:
- Parametrised successor to the fixed 4-phase clock generator.
- Produces NUM_PHASES mutually exclusive phase enables that rotate under one master clock.
- Adds a programmable per-phase width, a programmable non-overlap gap, a selectable rotation direction, enable with graceful stop, synchronous reset, and a cycle-start marker.
- Sits at the root of phased datapath/shift logic; all outputs are registered.

Parameters:
- NUM_PHASES, 4, number of phase outputs (must be >= 2).
- CNT_W, 8, width of the phase-length and gap-length inputs and of the internal down-counter.

Ports:
- clk  input  1  master clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  run request; 1 = run, 0 = stop after the current window.
- dir  input  1  rotation direction; 0 = ascending, 1 = descending.
- phase_len  input  CNT_W  cycles each phase is held high; 0 is treated as 1.
- gap_len  input  CNT_W  all-low dead cycles between consecutive phases; 0 = no gap.
- phase  output  NUM_PHASES  phase enables; one-hot or all-zero.
- phase_idx  output  $clog2(NUM_PHASES)  index of the current or most recent active phase.
- cycle_start  output  1  one-cycle pulse coinciding with the first cycle of each phase-0 window.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset
  - The reset is synchronous and active-low: rst_n sampled low at a posedge clk forces state=IDLE, phase=0, phase_idx=0, cycle_start=0, busy=0, counter=0.
  - Reset overrides en and all other inputs. Reset mid-window truncates the window immediately, with no gap.
- State machine: IDLE, ACTIVE, GAP.
- IDLE
  - phase=0, busy=0.
  - en=1 sampled at edge k: after edge k, state=ACTIVE, phase_idx=0, phase[0]=1, cycle_start=1, busy=1.
  - Latency from en to phase[0] is one edge. A restart always begins at index 0.
- ACTIVE
  - phase[phase_idx]=1 for L = max(phase_len,1) cycles. phase_len is latched on the edge that enters the window.
  - On the last cycle of the window:
    - en=0: go to IDLE, phase=0.
    - gap_len=0: enter the next index's ACTIVE window directly, back-to-back.
    - otherwise: enter GAP.
- GAP
  - phase=0 for G = gap_len cycles. gap_len is latched on entry. phase_idx holds.
  - en=0 sampled in GAP: go to IDLE on that edge.
  - At gap end: go to ACTIVE at the next index.
- Next index
  - dir=0: (idx+1) mod NUM_PHASES.
  - dir=1: idx==0 ? NUM_PHASES-1 : idx-1.
  - dir is sampled only on the edge that starts a new window. A change mid-window takes effect at the next transition.
- cycle_start: high for exactly the first cycle of every ACTIVE window with idx 0, including the start from IDLE. Otherwise low.
- Input changes: changes to phase_len or gap_len mid-window do not alter the current window.
- en glitch: en dropping and re-rising before a window ends has no effect; only the value on the window's final cycle matters.
- Invariant: popcount(phase) <= 1 every cycle. Never two phases simultaneously.
- Legacy compatibility: NUM_PHASES=4, phase_len=1, gap_len=0, dir=0, en=1 reproduces p0,p1,p2,p3 rotating one cycle each.

Test Plan:
1. Legacy mode.
   - Stimulus: NUM_PHASES=4, phase_len=1, gap_len=0, dir=0; rst_n low 2 cycles, then en=1.
   - Required: phase = 0001, 0010, 0100, 1000, 0001 on successive cycles; cycle_start high every 4th cycle aligned to 0001.
2. Width and gap.
   - Stimulus: phase_len=3, gap_len=2, dir=0.
   - Required: each phase high 3 cycles, then 2 cycles of 0000; period = 4*(3+2) = 20 cycles; cycle_start period 20.
3. Reverse direction plus mid-run flip.
   - Stimulus: dir=1, phase_len=1, gap_len=0.
   - Required: sequence 0001, 1000, 0100, 0010.
   - Stimulus: set dir=0 during the 0100 window.
   - Required: the next window is 1000, then 0001.
4. Graceful stop and restart.
   - Stimulus: phase_len=4; drop en during cycle 2 of phase[1] and hold it low.
   - Required: phase[1] stays high 4 cycles total, then 0000 and busy=0.
   - Stimulus: re-raise en.
   - Required: phase[0] and cycle_start one edge later.
5. Synchronous reset mid-window.
   - Stimulus: rst_n low during GAP, then during ACTIVE.
   - Required: outputs clear on the same sampling edge (not asynchronously before it); after release with en=1, restart at index 0.
6. Parameter and boundary sweep.
   - Stimulus: NUM_PHASES=3 and NUM_PHASES=8; phase_len=0 (treated as 1); gap_len=255; phase_len changed mid-window.
   - Required: correct wrap (2 to 0 ascending, 0 to 7 descending); current window length unchanged; one-hot/zero invariant holds throughout.
